// File: rtl/mmul2_pkg.sv
// Shared types and constants for the matrix-multiply index sequencer.
package mmul2_pkg;

   localparam int unsigned     IDX_W   = 32;
   localparam longint unsigned DIM_MAX = 64'h1_0000_0000;

   typedef logic [IDX_W-1:0] mmul2_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mmul2_seq_state_e;

   // A loop dimension is legal when it is non-empty and fits 32-bit indexing.
   function automatic logic dim_ok(input longint unsigned d);
      return (d >= 64'd1) && (d <= DIM_MAX);
   endfunction

endpackage

// File: rtl/mmul2_wrap_ctr.sv
// Modulo-LIMIT index counter; wrap flags the increment that returns it to zero.
module mmul2_wrap_ctr
   import mmul2_pkg::*;
#(
   parameter longint unsigned LIMIT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output mmul2_idx_t cnt,
   output logic       wrap
);

   localparam mmul2_idx_t MAX_CNT = IDX_W'(LIMIT - 64'd1);

   assign wrap = inc && (cnt == MAX_CNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= wrap ? '0 : cnt + IDX_W'(1);
      end
   end

endmodule

// File: rtl/mmul2_sequencer.sv
// Walks (i, j, k) with k innermost over a valid/ready stream, then pulses done.
// Optional accumulator flags acc_first/acc_last are built with MMUL2_SEQ_ACC_FLAGS_EN.
module mmul2_sequencer
   import mmul2_pkg::*;
#(
   parameter longint unsigned RA = 2,
   parameter longint unsigned CA = 2,
   parameter longint unsigned RB = 2,
   parameter longint unsigned CB = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       ready,
   output logic       valid,
   output mmul2_idx_t i,
   output mmul2_idx_t j,
   output mmul2_idx_t k,
   output logic       last,
   output logic       busy,
   output logic       done
`ifdef MMUL2_SEQ_ACC_FLAGS_EN
   ,
   output logic       acc_first,
   output logic       acc_last
`endif
);

   localparam mmul2_idx_t I_MAX = IDX_W'(RA - 64'd1);
   localparam mmul2_idx_t J_MAX = IDX_W'(CB - 64'd1);
   localparam mmul2_idx_t K_MAX = IDX_W'(RB - 64'd1);

   if (!dim_ok(RA) || !dim_ok(CB) || !dim_ok(RB)) begin : g_bad_dim
      $error("mmul2_sequencer: RA, CB and RB must lie in 1..2^32");
   end
   if (CA != RB) begin : g_bad_inner
      $error("mmul2_sequencer: CA must equal RB");
   end

   mmul2_seq_state_e state;
   mmul2_seq_state_e state_n;

   logic xfer;
   logic clr;
   logic k_wrap;
   logic j_wrap;
   logic i_wrap;

   assign xfer = valid && ready;
   assign clr  = (state == IDLE);

   // Chained counters: each wrap carries into the next-outer index.
   mmul2_wrap_ctr #(.LIMIT(RB)) u_k_ctr (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .inc  (xfer),
      .cnt  (k),
      .wrap (k_wrap)
   );

   mmul2_wrap_ctr #(.LIMIT(CB)) u_j_ctr (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .inc  (k_wrap),
      .cnt  (j),
      .wrap (j_wrap)
   );

   mmul2_wrap_ctr #(.LIMIT(RA)) u_i_ctr (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .inc  (j_wrap),
      .cnt  (i),
      .wrap (i_wrap)
   );

   assign last = valid && (i == I_MAX) && (j == J_MAX) && (k == K_MAX);

`ifdef MMUL2_SEQ_ACC_FLAGS_EN
   assign acc_first = valid && (k == '0);
   assign acc_last  = valid && (k == K_MAX);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // i_wrap fires exactly on acceptance of the final tuple.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (i_wrap) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Status outputs registered from the next state so they align with state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         valid <= (state_n == RUN);
         busy  <= (state_n != IDLE);
         done  <= (state_n == DONE);
      end
   end

endmodule

// File: tb/tb_mmul2_sequencer.sv
// Scoreboard bench for mmul2_sequencer: 2x2x2 sweeps plus a 1x1x1 instance.
module tb_mmul2_sequencer;

   typedef struct packed {
      logic [31:0] i;
      logic [31:0] j;
      logic [31:0] k;
      logic        last;
   } tup_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, ready, start1, ready1;
   logic        valid, last, busy, done;
   logic [31:0] i, j, k;
   logic        valid1, last1, busy1, done1;
   logic [31:0] i1, j1, k1;
`ifdef MMUL2_SEQ_ACC_FLAGS_EN
   logic        acc_first, acc_last, acc_first1, acc_last1;
`endif

   int   total = 0;
   int   bad   = 0;
   tup_t expq[$];
   tup_t held;
   bit   hold_pend = 1'b0;

   always #5 clk = ~clk;

   mmul2_sequencer #(.RA(2), .CA(2), .RB(2), .CB(2)) dut (
      .clk(clk), .rst(rst), .start(start), .ready(ready),
      .valid(valid), .i(i), .j(j), .k(k), .last(last), .busy(busy), .done(done)
`ifdef MMUL2_SEQ_ACC_FLAGS_EN
      , .acc_first(acc_first), .acc_last(acc_last)
`endif
   );

   mmul2_sequencer #(.RA(1), .CA(1), .RB(1), .CB(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .ready(ready1),
      .valid(valid1), .i(i1), .j(j1), .k(k1), .last(last1), .busy(busy1), .done(done1)
`ifdef MMUL2_SEQ_ACC_FLAGS_EN
      , .acc_first(acc_first1), .acc_last(acc_last1)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Expected 2x2x2 tuples in k-innermost order.
   task automatic push_first(input int n);
      int cnt = 0;
      for (int ii = 0; ii < 2; ii++)
         for (int jj = 0; jj < 2; jj++)
            for (int kk = 0; kk < 2; kk++) begin
               if (cnt < n)
                  expq.push_back('{32'(ii), 32'(jj), 32'(kk), (ii == 1 && jj == 1 && kk == 1)});
               cnt++;
            end
   endtask

   // Monitor: pops on every accepted tuple and checks held tuples under backpressure.
   always @(negedge clk) begin
      tup_t e;
      if (rst) begin
         hold_pend = 1'b0;
      end else if (valid) begin
         if (hold_pend)
            chk("hold_tuple", {i[7:0], j[7:0], k[7:0], 7'd0, last},
                {held.i[7:0], held.j[7:0], held.k[7:0], 7'd0, held.last});
         hold_pend = 1'b0;
         if (ready) begin
            if (expq.size() == 0) begin
               chk("unexpected_tuple", 32'd1, 32'd0);
            end else begin
               e = expq.pop_front();
               chk("tuple_i", i, e.i);
               chk("tuple_j", j, e.j);
               chk("tuple_k", k, e.k);
               chk("tuple_last", 32'(last), 32'(e.last));
`ifdef MMUL2_SEQ_ACC_FLAGS_EN
               chk("acc_first", 32'(acc_first), 32'(e.k == 32'd0));
               chk("acc_last", 32'(acc_last), 32'(e.k == 32'd1));
`endif
            end
         end else begin
            held      = '{i, j, k, last};
            hold_pend = 1'b1;
         end
      end else begin
         chk("idle_last", 32'(last), 32'd0);
`ifdef MMUL2_SEQ_ACC_FLAGS_EN
         chk("idle_acc", {30'd0, acc_first, acc_last}, 32'd0);
`endif
      end
   end

   // One full sweep; optional stall window and start pulses in RUN and DONE.
   task automatic run_sweep(input int stall_at, input int stall_len, input bit restart,
                            input string tag);
      int lat = -1;
      int exp_lat = 8 + stall_len;
      push_first(8);
      @(posedge clk); #1 start = 1'b1; ready = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 0; c < 60; c++) begin
         ready = !(c >= stall_at && c < stall_at + stall_len);
         start = restart && (c == 2 || c == exp_lat);
         #2;
         if (lat >= 0) begin
            chk({tag, "_done_width"}, 32'(done), 32'd0);
            chk({tag, "_idle_valid"}, 32'(valid), 32'd0);
            break;
         end
         if (done) lat = c;
         @(posedge clk); #1;
      end
      start = 1'b0;
      ready = 1'b1;
      chk({tag, "_done_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_queue_empty"}, 32'(expq.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ready = 1'b0; start1 = 1'b0; ready1 = 1'b1;
      #2;
      chk("rst_outs", {26'd0, valid, busy, done, last, valid1, done1}, 32'd0);
      chk("rst_idx", i | j | k, 32'd0);
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;

      run_sweep(100, 0, 1'b0, "plain");
      run_sweep(3, 3, 1'b0, "stall");
      run_sweep(100, 0, 1'b1, "restart");
      run_sweep(100, 0, 1'b0, "after_restart");

      // Degenerate 1x1x1: single tuple carries last.
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      #2;
      chk("one_valid", {30'd0, valid1, last1}, 32'd3);
      chk("one_idx", i1 | j1 | k1, 32'd0);
      chk("one_early_done", 32'(done1), 32'd0);
      @(posedge clk); #3;
      chk("one_done", {30'd0, done1, valid1}, 32'd2);
      @(posedge clk); #3;
      chk("one_idle", {30'd0, done1, busy1}, 32'd0);

      // Reset mid-sweep while tuple (1,0,1) is presented.
      push_first(5);
      @(posedge clk); #1 start = 1'b1; ready = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      #1;
      chk("pre_rst_tuple", {i[7:0], j[7:0], k[7:0], 7'd0, valid}, {8'd1, 8'd0, 8'd1, 8'd1});
      #1 rst = 1'b1;
      #1;
      chk("async_rst_outs", {28'd0, valid, busy, done, last}, 32'd0);
      chk("async_rst_idx", i | j | k, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      chk("rst_queue_empty", 32'(expq.size()), 32'd0);
      run_sweep(100, 0, 1'b0, "post_rst");

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
